// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter and its helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_BUSY    = 3'b010,
    ST_RECOVER = 3'b100
  } arb_state_t;

  localparam int unsigned REQ_ICACHE      = 0;
  localparam int unsigned REQ_DCACHE      = 1;
  localparam int unsigned REQ_UNCACHE     = 2;
  localparam int unsigned DEFAULT_TIMEOUT = 1023;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared simple memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 32
);
  logic [NUM_REQ-1:0]         req_en;
  logic [4*NUM_REQ-1:0]       req_wsel;
  logic [ADDR_WD*NUM_REQ-1:0] req_addr;
  logic [DATA_WD*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]         req_reload;
  logic [DATA_WD-1:0]         req_rdata;
  logic                       mem_en;
  logic [3:0]                 mem_wsel;
  logic [ADDR_WD-1:0]         mem_addr;
  logic [DATA_WD-1:0]         mem_wdata;
  logic                       mem_reload;
  logic [DATA_WD-1:0]         mem_rdata;

  modport master (
    input  req_en, req_wsel, req_addr, req_wdata, mem_reload, mem_rdata,
    output req_reload, req_rdata, mem_en, mem_wsel, mem_addr, mem_wdata
  );

  modport slave (
    output req_en, req_wsel, req_addr, req_wdata, mem_reload, mem_rdata,
    input  req_reload, req_rdata, mem_en, mem_wsel, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);
  logic [PTR_W-1:0] w_j;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_j      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_valid && i_req[w_j]) begin
        o_valid       = 1'b1;
        o_idx         = w_j;
        o_onehot[w_j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one simple memory port among NUM_REQ requesters,
// with a per-transaction watchdog that completes a hung request with zero data.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus,
  output logic [NUM_REQ-1:0]  grant,
  output logic                timeout_err,
  input  logic                err_clr
);
  localparam int unsigned      PTR_W    = ptr_width(NUM_REQ);
  localparam int unsigned      WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_t         r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_win;
  logic [WD_W-1:0]    r_wd;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_err;
  logic               r_mem_en;
  logic [3:0]         r_mem_wsel;
  logic [ADDR_WD-1:0] r_mem_addr;
  logic [DATA_WD-1:0] r_mem_wdata;

  logic [NUM_REQ-1:0] w_onehot;
  logic [PTR_W-1:0]   w_idx;
  logic               w_valid;
  logic [3:0]         w_sel_wsel;
  logic [ADDR_WD-1:0] w_sel_addr;
  logic [DATA_WD-1:0] w_sel_wdata;
  logic               w_timeout;
  logic               w_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .i_req    (bus.req_en),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // AND-OR mux of the winner's request fields
  always_comb begin
    w_sel_wsel  = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_onehot[k]) begin
        w_sel_wsel  |= bus.req_wsel[k*4 +: 4];
        w_sel_addr  |= bus.req_addr[k*ADDR_WD +: ADDR_WD];
        w_sel_wdata |= bus.req_wdata[k*DATA_WD +: DATA_WD];
      end
    end
  end

  // Fires in the TIMEOUT-th BUSY cycle that lacks mem_reload
  assign w_timeout = (TIMEOUT != 0) && (r_state == ST_BUSY) && !bus.mem_reload && (r_wd == WD_LAST);
  assign w_done    = (r_state == ST_BUSY) && (bus.mem_reload || w_timeout);

  assign bus.req_reload = w_done ? r_grant : '0;
  assign bus.req_rdata  = w_timeout ? '0 : bus.mem_rdata;
  assign bus.mem_en     = r_mem_en;
  assign bus.mem_wsel   = r_mem_wsel;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign grant          = r_grant;
  assign timeout_err    = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_wd        <= '0;
      r_grant     <= '0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wsel  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_timeout)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_grant     <= w_onehot;
            r_win       <= w_idx;
            r_mem_en    <= 1'b1;
            r_mem_wsel  <= w_sel_wsel;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_wd        <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_grant     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wsel  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ptr       <= (r_win == PTR_LAST) ? '0 : r_win + 1'b1;
            r_state     <= ST_RECOVER;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        ST_RECOVER: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single simple memory port (en / wsel / addr / wdata / reload / rdata) between NUM_REQ requesters: icache refill, dcache refill/writeback and uncache.
- Sits between those requesters and the AXI bridge.
- Each requester drives the same request protocol it would drive straight to the bridge.
- The arbiter grants one requester at a time with round-robin priority, forwards its request, routes the reload/rdata back, and supervises each transaction with a watchdog.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = icache, 1 = dcache, 2 = uncache)
ADDR_WD, 32, address width
DATA_WD, 32, data width
TIMEOUT, 1023, cycles a granted transaction may wait for reload before error (0 = watchdog disabled)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_en  in  NUM_REQ  per-requester request valid; held until that requester's reload
req_wsel  in  4*NUM_REQ  per-requester byte write enables; 0 = read
req_addr  in  ADDR_WD*NUM_REQ  per-requester address
req_wdata  in  DATA_WD*NUM_REQ  per-requester write data
req_reload  out  NUM_REQ  one-cycle completion pulse to the granted requester
req_rdata  out  DATA_WD  read data; valid only in a cycle where a req_reload bit is high
mem_en  out  1  downstream request valid
mem_wsel  out  4  downstream byte enables
mem_addr  out  ADDR_WD  downstream address
mem_wdata  out  DATA_WD  downstream write data
mem_reload  in  1  downstream completion pulse
mem_rdata  in  DATA_WD  downstream read data, valid with mem_reload
grant  out  NUM_REQ  one-hot current owner; 0 when idle
timeout_err  out  1  sticky watchdog error flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state = IDLE, rr_ptr = 0, watchdog count = 0, timeout_err = 0.
  - mem_en, mem_wsel, mem_addr, mem_wdata, grant all 0.
- Reset mid-transaction aborts it: no req_reload is issued, and any later mem_reload arriving in IDLE is ignored.
- State IDLE:
  - If any req_en bit is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - On the next edge: grant <= one-hot(winner), latch that requester's wsel/addr/wdata into mem_*, mem_en <= 1, state <= BUSY.
  - Latency from req_en to mem_en is 1 cycle.
- State BUSY:
  - mem_* are held stable; requester inputs are not re-sampled.
  - req_reload = grant & {NUM_REQ{mem_reload}} (combinational).
  - req_rdata = mem_rdata (combinational, shared by all requesters).
  - On mem_reload: mem_en/mem_wsel/mem_addr/mem_wdata <= 0, grant <= 0, rr_ptr <= winner+1 (wrapping to 0 after NUM_REQ-1), state <= RECOVER.
- State RECOVER (exactly 1 cycle):
  - No grant is issued; state <= IDLE.
  - Purpose: requesters drop req_en registered on reload, so their request is still visible for one cycle and must not be re-granted.
- mem_reload outside BUSY is ignored and produces no req_reload.
- Watchdog:
  - Counter is cleared on entry to BUSY and increments each BUSY cycle without mem_reload.
  - When the count reaches TIMEOUT:
    - timeout_err <= 1;
    - the granted requester receives a one-cycle req_reload with req_rdata forced to 0;
    - mem_* are cleared and state <= RECOVER.
  - With TIMEOUT = 0 the watchdog is inert.
- timeout_err stays set until err_clr. If err_clr and a new timeout occur in the same cycle, set wins.
- Simultaneous requests are resolved purely by rr_ptr. A requester that just completed has lowest priority next round, which guarantees no starvation.
- Requester contract: req_en together with its wsel/addr/wdata stays stable from assertion until its reload. Withdrawal before grant is allowed; withdrawal after grant is not.
- Throughput: at most one transaction in flight; minimum 3 cycles per transaction (issue, reload, recover).

Decomposition:
- Shared package/header holds:
  - state encodings (one-hot IDLE=3'b001, BUSY=3'b010, RECOVER=3'b100);
  - requester index constants (REQ_ICACHE=0, REQ_DCACHE=1, REQ_UNCACHE=2);
  - default TIMEOUT.
- Natural sub-module: rr_pick, purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner, winner index.
  - Reused by later arbiters.

Test Plan:
- Single read: req_en=3'b010, addr=0x1faf_fff0, wsel=0 → mem_en high the next cycle with mem_addr=0x1faf_fff0; mem_reload with rdata=0xDEADBEEF after 5 cycles → req_reload=3'b010 that cycle, req_rdata=0xDEADBEEF; mem_en=0 the next cycle; no regrant during RECOVER.
- Contention: all three req_en held, reload after 2 cycles each → grant order 001, 010, 100, 001 with rr_ptr wrapping; each requester gets exactly one reload per transaction.
- Write pass-through: uncache write wsel=4'b1111, wdata=0x12345678 → mem_wsel=4'hF and mem_wdata=0x12345678 held stable until reload, then cleared to 0.
- Stale request: requester 0 keeps req_en high one cycle after its reload while requester 2 is also requesting → requester 2 is granted next; requester 0 is not double-issued.
- Watchdog: TIMEOUT=8, no mem_reload → after 8 BUSY cycles timeout_err=1, req_reload pulses with rdata=0, state returns to IDLE via RECOVER; err_clr clears the flag.
- Reset mid-BUSY: assert rst during BUSY → all outputs 0 the next cycle; a subsequent mem_reload produces no req_reload.
